// File: rtl/cpu_run_monitor.sv
// Run-control monitor on the retire boundary: counts RUN cycles and
// retirements, and ends the run on a stop-address hit, a hung core or a
// cycle timeout. Terminal states hold until clear or reset.
module cpu_run_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_STOP       = 2,
  parameter int CNT_W          = 32,
  parameter int STALL_LIMIT    = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int IDX_W          = (NUM_STOP > 1) ? $clog2(NUM_STOP) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     arm,
  input  logic                     clear,
  input  logic                     retire_valid,
  input  logic [XLEN-1:0]          retire_pc,
  input  logic [NUM_STOP*XLEN-1:0] stop_addr,
  input  logic [NUM_STOP-1:0]      stop_en,
  output logic [2:0]               state,
  output logic                     done,
  output logic                     pass,
  output logic [IDX_W-1:0]         hit_idx,
  output logic [XLEN-1:0]          end_pc,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         retire_cnt
);

  localparam int               SW     = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0]    LIM    = SW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_HALT    = 3'd2,
    S_HANG    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t             st_q, st_d;
  logic               done_d, pass_d;
  logic [IDX_W-1:0]   hit_d;
  logic [XLEN-1:0]    pc_d;
  logic [CNT_W-1:0]   cyc_d, ret_d, cyc_inc, ret_inc;
  logic [SW-1:0]      idle_q, idle_d, same_q, same_d;
  logic               match_any;
  logic [IDX_W-1:0]   match_idx;

  assign state = st_q;

  // Saturating increments; counters stick at all-ones instead of wrapping
  assign cyc_inc = (cycle_cnt  == '1) ? cycle_cnt  : cycle_cnt  + CNT_W'(1);
  assign ret_inc = (retire_cnt == '1) ? retire_cnt : retire_cnt + CNT_W'(1);

  // Stop-address compare; the lowest matching enabled channel wins
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_STOP; i++) begin
      if (!match_any && retire_valid && stop_en[i] &&
          retire_pc == stop_addr[i*XLEN +: XLEN]) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // Next-state and next-output logic; end_pc doubles as the previous retired PC
  always_comb begin
    st_d   = st_q;
    hit_d  = hit_idx;
    pc_d   = end_pc;
    cyc_d  = cycle_cnt;
    ret_d  = retire_cnt;
    idle_d = idle_q;
    same_d = same_q;
    if (clear) begin
      st_d   = S_IDLE;
      hit_d  = '0;
      pc_d   = '0;
      cyc_d  = '0;
      ret_d  = '0;
      idle_d = '0;
      same_d = '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (arm) begin
            st_d   = S_RUN;
            hit_d  = '0;
            pc_d   = '0;
            cyc_d  = '0;
            ret_d  = '0;
            idle_d = '0;
            same_d = '0;
          end
        end
        S_RUN: begin
          cyc_d = cyc_inc;
          if (retire_valid) begin
            ret_d  = ret_inc;
            pc_d   = retire_pc;
            idle_d = '0;
            // same_q==0 means no earlier retirement in this run
            same_d = (same_q != '0 && retire_pc == end_pc) ? same_q + SW'(1) : SW'(1);
          end else begin
            idle_d = idle_q + SW'(1);
          end
          if (match_any) begin
            st_d  = S_HALT;
            hit_d = match_idx;
          end else if (idle_d == LIM || same_d == LIM) begin
            st_d = S_HANG;
          end else if (TMO_EN && cyc_inc == TMO) begin
            st_d = S_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
    done_d = (st_d == S_HALT) || (st_d == S_HANG) || (st_d == S_TIMEOUT);
    pass_d = (st_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      st_q       <= S_IDLE;
      done       <= 1'b0;
      pass       <= 1'b0;
      hit_idx    <= '0;
      end_pc     <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      idle_q     <= '0;
      same_q     <= '0;
    end else begin
      st_q       <= st_d;
      done       <= done_d;
      pass       <= pass_d;
      hit_idx    <= hit_d;
      end_pc     <= pc_d;
      cycle_cnt  <= cyc_d;
      retire_cnt <= ret_d;
      idle_q     <= idle_d;
      same_q     <= same_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: each run's outcome is predicted from
// the retire trace and queued; a monitor checks it when done rises.
module tb_cpu_run_monitor;

  localparam int XLEN  = 32;
  localparam int NSTOP = 2;
  localparam int STALL = 16;
  localparam int TMO   = 50;
  localparam int LEN   = 50;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              arm = 1'b0;
  logic              clear = 1'b0;
  logic              retire_valid = 1'b0;
  logic [XLEN-1:0]   retire_pc = '0;
  logic [2*XLEN-1:0] stop_addr = '0;
  logic [1:0]        stop_en = '0;
  logic [2:0]        state;
  logic              done, pass;
  logic [0:0]        hit_idx;
  logic [XLEN-1:0]   end_pc;
  logic [31:0]       cycle_cnt, retire_cnt;

  cpu_run_monitor #(
    .XLEN(XLEN), .NUM_STOP(NSTOP), .CNT_W(32),
    .STALL_LIMIT(STALL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .clear(clear),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .stop_addr(stop_addr), .stop_en(stop_en),
    .state(state), .done(done), .pass(pass), .hit_idx(hit_idx),
    .end_pc(end_pc), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [0:0]  idx;
    logic [31:0] pc;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tot = 0;
  int          n_bad = 0;
  bit          tr_v[LEN];
  logic [31:0] tr_pc[LEN];
  logic [31:0] cfg_a0, cfg_a1;
  logic [1:0]  cfg_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: scan the trace, cycle k+1 consumes entry k; first rule to fire ends the run
  function automatic exp_t model();
    exp_t r;
    int idle, run, hit;
    bit have;
    logic [31:0] prev;
    r = '0; idle = 0; run = 0; have = 0; prev = '0;
    r.st = 3'd1;
    for (int k = 0; k < LEN; k++) begin
      r.cyc = k + 1;
      if (tr_v[k]) begin
        r.ret = r.ret + 1;
        r.pc  = tr_pc[k];
        run   = (have && tr_pc[k] == prev) ? run + 1 : 1;
        prev  = tr_pc[k];
        have  = 1;
        idle  = 0;
      end else begin
        idle++;
      end
      hit = -1;
      if (tr_v[k] && cfg_en[1] && tr_pc[k] == cfg_a1) hit = 1;
      if (tr_v[k] && cfg_en[0] && tr_pc[k] == cfg_a0) hit = 0;
      if (hit >= 0) begin r.st = 3'd2; r.idx = hit[0:0]; return r; end
      if (idle >= STALL || run >= STALL) begin r.st = 3'd3; return r; end
      if (k + 1 == TMO) begin r.st = 3'd4; return r; end
    end
    return r;
  endfunction

  task automatic build(input int mode);
    cfg_a0 = 32'h78; cfg_a1 = 32'hFFFF_FFF1; cfg_en = 2'b00;
    case (mode)
      0: cfg_en = 2'b01;
      1: begin
        cfg_a0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        cfg_a1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        cfg_en = 2'($urandom_range(0, 3));
      end
      2, 3, 4: cfg_en = 2'b00;
      5: begin cfg_a0 = 32'hC4; cfg_en = 2'b01; end
      6: begin cfg_a0 = 32'h40; cfg_a1 = 32'h40; cfg_en = 2'b11; end
      7: begin cfg_a0 = 32'h40; cfg_a1 = 32'h40; cfg_en = 2'b10; end
      default: ;
    endcase
    for (int k = 0; k < LEN; k++) begin
      case (mode)
        1: begin
          tr_v[k]  = ($urandom_range(0, 3) != 0);
          tr_pc[k] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end
        2: begin tr_v[k] = 1'b1; tr_pc[k] = 32'h10; end
        3: begin tr_v[k] = 1'b0; tr_pc[k] = 32'h10; end
        4: begin tr_v[k] = 1'b1; tr_pc[k] = 32'h1000 + 32'(k * 4); end
        default: begin tr_v[k] = 1'b1; tr_pc[k] = 32'(k * 4); end
      endcase
    end
  endtask

  task automatic do_run(input int mode);
    exp_t e;
    build(mode);
    e = model();
    exp_q.push_back(e);
    @(posedge clk); #1;
    stop_addr    = {cfg_a1, cfg_a0};
    stop_en      = cfg_en;
    arm          = 1'b1;
    retire_valid = 1'($urandom_range(0, 1));
    retire_pc    = cfg_a0;
    @(posedge clk); #1;
    chk("armed_state", state, 3'd1);
    chk("armed_cycle", cycle_cnt, 0);
    arm = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      retire_valid = tr_v[k];
      retire_pc    = tr_pc[k];
      @(posedge clk); #1;
    end
    // keep retiring and pulse arm: terminal state must hold
    for (int k = 0; k < 3; k++) begin
      arm          = 1'b1;
      retire_valid = 1'b1;
      retire_pc    = cfg_a0;
      @(posedge clk); #1;
    end
    arm = 1'b0; retire_valid = 1'b0;
    @(negedge clk);
    if (!done) begin
      n_tot++; n_bad++;
      $display("FAIL run_end_missing actual=done0 required=done1 mode=%0d", mode);
      exp_q.delete();
    end
    chk("sticky_state", state, e.st);
    chk("sticky_cycle", cycle_cnt, e.cyc);
    chk("sticky_retire", retire_cnt, e.ret);
    chk("sticky_pc", end_pc, e.pc);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_state", state, 3'd0);
    chk("clear_done", {done, pass}, 2'b00);
    chk("clear_cycle", cycle_cnt, 0);
    chk("clear_retire", retire_cnt, 0);
    chk("clear_pc", end_pc, 0);
  endtask

  // Monitor: on each rising done, compare the DUT status with the oldest prediction
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (exp_q.size() == 0) begin
          n_tot++; n_bad++;
          $display("FAIL unexpected_done actual=state%0d required=no_end", state);
        end else begin
          e = exp_q.pop_front();
          chk("end_state", state, e.st);
          chk("end_pass", pass, (e.st == 3'd2));
          if (e.st == 3'd2) chk("end_hit_idx", hit_idx, e.idx);
          chk("end_pc", end_pc, e.pc);
          chk("end_cycle", cycle_cnt, e.cyc);
          chk("end_retire", retire_cnt, e.ret);
        end
      end
      prev = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("reset_state", state, 3'd0);
    chk("reset_outs", {done, pass, hit_idx, end_pc, cycle_cnt, retire_cnt}, '0);
    // asynchronous reset in the middle of a run
    @(posedge clk); #1;
    arm = 1'b1; stop_en = 2'b00;
    @(posedge clk); #1;
    arm = 1'b0; retire_valid = 1'b1; retire_pc = 32'h24;
    repeat (4) @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    chk("async_reset_state", state, 3'd0);
    chk("async_reset_outs", {done, pass, hit_idx, end_pc, cycle_cnt, retire_cnt}, '0);
    #14 rstn = 1'b0;
    retire_valid = 1'b0;
    for (int m = 0; m < 8; m++) begin
      if (m != 1) do_run(m);
    end
    for (int n = 0; n < 25; n++) do_run(1);
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
